// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST controller: sequencer states, the
// march element table and run-length constants.
package mbist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic desc;
    logic rd;
    logic wr;
    logic rval;
    logic wval;
  } elem_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int DEF_WORDS    = 16;
  localparam int TOTAL_CYCLES = 10 * DEF_WORDS + 3;

  // Non-march states map to an all-zero entry: no read, no write.
  function automatic elem_t march_elem(input state_e s);
    case (s)
      ST_M0:   return '{desc: 1'b0, rd: 1'b0, wr: 1'b1, rval: 1'b0, wval: 1'b0};
      ST_M1:   return '{desc: 1'b0, rd: 1'b1, wr: 1'b1, rval: 1'b0, wval: 1'b1};
      ST_M2:   return '{desc: 1'b0, rd: 1'b1, wr: 1'b1, rval: 1'b1, wval: 1'b0};
      ST_M3:   return '{desc: 1'b1, rd: 1'b1, wr: 1'b1, rval: 1'b0, wval: 1'b1};
      ST_M4:   return '{desc: 1'b1, rd: 1'b1, wr: 1'b1, rval: 1'b1, wval: 1'b0};
      ST_M5:   return '{desc: 1'b0, rd: 1'b1, wr: 1'b0, rval: 1'b0, wval: 1'b0};
      default: return '0;
    endcase
  endfunction

  function automatic state_e next_elem(input state_e s);
    case (s)
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      default: return ST_DRAIN;
    endcase
  endfunction

endpackage

// File: rtl/mbist_resp_cmp.sv
// Read-response checker: carries expected word and address alongside each
// read for two cycles, then compares against rdata and accumulates results.
module mbist_resp_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] exp_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [FCNT_WIDTH-1:0] fail_count
);

  logic                  vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [DATA_WIDTH-1:0] exp_p1_q, exp_p1_d, exp_p2_q, exp_p2_d;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p1_d, addr_p2_q, addr_p2_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  mismatch;

  function automatic logic [FCNT_WIDTH-1:0] sat_inc(input logic [FCNT_WIDTH-1:0] v);
    return (&v) ? v : v + FCNT_WIDTH'(1);
  endfunction

  always_comb begin
    vld_p1_d  = push;
    exp_p1_d  = exp_in;
    addr_p1_d = addr_in;
    vld_p2_d  = vld_p1_q;
    exp_p2_d  = exp_p1_q;
    addr_p2_d = addr_p1_q;
    // Case inequality so an undriven or X read response is a failure.
    mismatch  = vld_p2_q && (rdata !== exp_p2_q);
    fail_d    = fail_q;
    faddr_d   = faddr_q;
    fcnt_d    = fcnt_q;
    if (clear) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      fcnt_d  = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) faddr_d = addr_p2_q;
      fcnt_d = sat_inc(fcnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      fail_q   <= 1'b0;
      faddr_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      fail_q   <= fail_d;
      faddr_q  <= faddr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    exp_p1_q  <= exp_p1_d;
    addr_p1_q <= addr_p1_d;
    exp_p2_q  <= exp_p2_d;
    addr_p2_q <= addr_p2_d;
  end

  assign bist_fail  = fail_q;
  assign fail_addr  = faddr_q;
  assign fail_count = fcnt_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: walks the six march elements over the memory,
// stages write data ahead of each element and feeds reads to the checker.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [FCNT_WIDTH-1:0] fail_count,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int DCNT_W = $clog2(DRAIN_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_HI = ADDR_WIDTH'(CAPACITY);

  state_e                state_q, state_d, nxt_state;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, end_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  phase_q, phase_d;
  logic [DCNT_W-1:0]     drain_q, drain_d;
  elem_t                 el, nel;
  logic                  rd_slot, wr_slot, start_ok;

  // phase_q selects the read (0) or write (1) slot of a two-operation element.
  always_comb begin
    el        = march_elem(state_q);
    nxt_state = next_elem(state_q);
    nel       = march_elem(nxt_state);
    rd_slot   = el.rd && !phase_q;
    wr_slot   = el.wr && (phase_q || !el.rd);
    end_addr  = el.desc ? '0 : ADDR_HI;
    start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    phase_d = phase_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETUP;
          addr_d  = '0;
          wdata_d = '0;
          phase_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_M0;
        wdata_d = {DATA_WIDTH{march_elem(ST_M0).wval}};
      end
      ST_DRAIN: begin
        if (drain_q == DCNT_W'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
        else                                       drain_d = drain_q + DCNT_W'(1);
      end
      default: begin
        if (el.rd && el.wr && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == end_addr) begin
            state_d = nxt_state;
            if (nxt_state == ST_DRAIN) begin
              drain_d = '0;
            end else begin
              addr_d  = nel.desc ? ADDR_HI : '0;
              wdata_d = {DATA_WIDTH{nel.wval}};
            end
          end else begin
            addr_d = el.desc ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      phase_q <= 1'b0;
      drain_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    write_read = wr_slot;
    address    = addr_q;
    wdata      = wdata_q;
    bist_busy  = !(state_q == ST_IDLE || state_q == ST_DONE);
    bist_done  = (state_q == ST_DONE);
  end

  mbist_resp_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .FCNT_WIDTH(FCNT_WIDTH)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .push      (rd_slot),
    .exp_in    ({DATA_WIDTH{el.rval}}),
    .addr_in   (addr_q),
    .rdata     (rdata),
    .bist_fail (bist_fail),
    .fail_addr (fail_addr),
    .fail_count(fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty SRAM environment, an operation-list
// reference model of the March C- run, and a per-cycle output compare.
module tb_mbist_march_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int CAP  = 15;
  localparam int FW   = 8;
  localparam int N    = CAP + 1;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          bist_busy, bist_done, bist_fail, write_read;
  logic [AW-1:0] fail_addr, address;
  logic [FW-1:0] fail_count;
  logic [DW-1:0] wdata, rdata;

  int checks   = 0;
  int failures = 0;

  mbist_march_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .FCNT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_count(fail_count),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Fault config: 0 none, 1 stuck-at-1, 2 stuck-at-0 (bit fb of word fa),
  // 3 wrong-address (write to fa lands on fa+1 with bit 1 inverted).
  int ft = 0, fa = 0, fb = 0;

  function automatic logic [AW-1:0] f_waddr(input logic [AW-1:0] a);
    return (ft == 3 && int'(a) == fa) ? a + AW'(1) : a;
  endfunction

  function automatic logic [DW-1:0] f_wdat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return (ft == 3 && int'(a) == fa) ? d ^ DW'(2) : d;
  endfunction

  function automatic logic [DW-1:0] f_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (ft == 1 && int'(a) == fa) return d | (DW'(1) << fb);
    if (ft == 2 && int'(a) == fa) return d & ~(DW'(1) << fb);
    return d;
  endfunction

  // Memory under test: write uses wdata from the previous edge, read data is
  // registered twice so it is valid at the second edge after the command.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] init_mem [N];
  logic [DW-1:0] wdata_prev, rd_p1;
  logic          mem_load = 1'b0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
    end else if (write_read === 1'b1) begin
      mem[f_waddr(address)] <= f_wdat(address, wdata_prev);
    end
    wdata_prev <= wdata;
    rd_p1      <= f_read(address, mem[address]);
    rdata      <= rd_p1;
  end

  // Reference plan: the flat list of March C- operations and, per read,
  // whether the faulty memory returns something other than the expected word.
  logic          op_wr [NOPS];
  logic          op_rd [NOPS];
  logic          op_mm [NOPS];
  logic [AW-1:0] op_addr [NOPS];
  logic [DW-1:0] op_wd [NOPS];

  task automatic build_plan();
    logic [DW-1:0] ref_mem [N];
    bit el_desc [6];
    bit el_rd [6];
    bit el_wr [6];
    bit el_rv [6];
    bit el_wv [6];
    logic [AW-1:0] a;
    int j;
    el_desc = '{0, 0, 0, 1, 1, 0};
    el_rd   = '{0, 1, 1, 1, 1, 1};
    el_wr   = '{1, 1, 1, 1, 1, 0};
    el_rv   = '{0, 0, 1, 0, 1, 0};
    el_wv   = '{0, 1, 0, 1, 0, 0};
    j = 0;
    for (int i = 0; i < N; i++) ref_mem[i] = init_mem[i];
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = el_desc[e] ? AW'(N - 1 - i) : AW'(i);
        if (el_rd[e]) begin
          op_wr[j] = 1'b0; op_rd[j] = 1'b1; op_addr[j] = a; op_wd[j] = {DW{el_wv[e]}};
          op_mm[j] = (f_read(a, ref_mem[a]) !== {DW{el_rv[e]}});
          j++;
        end
        if (el_wr[e]) begin
          op_wr[j] = 1'b1; op_rd[j] = 1'b0; op_addr[j] = a; op_wd[j] = {DW{el_wv[e]}};
          op_mm[j] = 1'b0;
          ref_mem[f_waddr(a)] = f_wdat(a, {DW{el_wv[e]}});
          j++;
        end
      end
    end
  endtask

  // Model: m_e counts edges since the accepting edge; op j is on the bus
  // after edge j+1 and its read result is judged at edge j+4.
  int            m_e = 0;
  bit            m_active = 0;
  logic          m_done, m_fail, m_wr;
  logic [AW-1:0] m_addr, m_faddr;
  logic [DW-1:0] m_wd;
  logic [FW-1:0] m_fcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_e = 0; m_done = 0; m_fail = 0; m_faddr = '0;
      m_fcnt = '0; m_wr = 0; m_addr = '0; m_wd = '0;
    end else if (m_active) begin
      m_e++;
      if (m_e <= NOPS) begin
        m_wr = op_wr[m_e-1]; m_addr = op_addr[m_e-1]; m_wd = op_wd[m_e-1];
      end else begin
        m_wr = 1'b0;
      end
      if (m_e >= 4 && m_e - 4 < NOPS && op_rd[m_e-4] && op_mm[m_e-4]) begin
        if (!m_fail) m_faddr = op_addr[m_e-4];
        m_fail = 1'b1;
        if (m_fcnt != '1) m_fcnt = m_fcnt + FW'(1);
      end
      if (m_e == NOPS + 3) begin
        m_active = 0; m_done = 1'b1;
      end
    end else if (start) begin
      m_active = 1; m_e = 0; m_done = 0; m_fail = 0; m_faddr = '0;
      m_fcnt = '0; m_wr = 0; m_addr = '0; m_wd = '0;
    end
  end

  always @(negedge clk) begin
    chk("write_read", 32'(write_read), 32'(m_wr));
    chk("address",    32'(address),    32'(m_addr));
    chk("wdata",      32'(wdata),      32'(m_wd));
    chk("bist_busy",  32'(bist_busy),  32'(m_active));
    chk("bist_done",  32'(bist_done),  32'(m_done));
    chk("bist_fail",  32'(bist_fail),  32'(m_fail));
    chk("fail_addr",  32'(fail_addr),  32'(m_faddr));
    chk("fail_count", 32'(fail_count), 32'(m_fcnt));
  end

  task automatic load_cfg(input int t, input int a, input int b, input bit rnd);
    ft = t; fa = a; fb = b;
    for (int i = 0; i < N; i++) init_mem[i] = rnd ? DW'($urandom) : DW'('hA5);
    build_plan();
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
  endtask

  task automatic run(input int t, input int a, input int b, input bit rnd,
                     input bit repulse, output int lat);
    load_cfg(t, a, b, rnd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("acc_busy", 32'(bist_busy), 1);
    chk("acc_done", 32'(bist_done), 0);
    chk("acc_fail", 32'(bist_fail), 0);
    chk("acc_cnt",  32'(fail_count), 0);
    lat = 0;
    while (bist_done !== 1'b1 && lat < 1000) begin
      start = repulse && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N; i++) init_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bist_busy, bist_done, bist_fail, write_read, fail_addr,
                        fail_count, address, wdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 0, 0, 0, 1, lat);
    chk("lat_clean", lat, 163);
    chk("clean_fail", 32'(bist_fail), 0);
    chk("clean_cnt", 32'(fail_count), 0);
    repeat (3) @(negedge clk);

    run(1, 9, 3, 0, 0, lat);
    chk("lat_stuck", lat, 163);
    chk("stuck_fail", 32'(bist_fail), 1);
    chk("stuck_addr", 32'(fail_addr), 9);
    chk("stuck_cnt", 32'(fail_count), 3);

    run(3, 5, 0, 0, 0, lat);
    chk("lat_wa", lat, 163);
    chk("wa_fail", 32'(bist_fail), 1);
    chk("wa_addr", 32'(fail_addr), 5);
    chk("wa_cnt_ge2", 32'(fail_count >= 2), 1);
    repeat (2) @(negedge clk);

    load_cfg(0, 0, 0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * N + 10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bist_busy, bist_done, bist_fail, write_read, fail_addr,
                           fail_count, address, wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(bist_busy), 0);
    chk("post_rst_done", 32'(bist_done), 0);
    run(0, 0, 0, 1, 0, lat);
    chk("lat_after_rst", lat, 163);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, CAP)),
          int'($urandom_range(0, DW - 1)), 1, 1, lat);
      chk("lat_rand", lat, 163);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
